// File: rtl/win_conv.sv
// Per-lane WIN_SIZE x WIN_SIZE signed-kernel convolution with round, normalise and clamp.
// Latency: 4 clk_i cycles, input to output, for data, valid and sideband flags.
// Backpressure: none; the pipeline advances every cycle.
//
// Ports:
//   clk_i, rst_n_i                     clock, async active-low reset
//   win_data_i [lane][row][col]        input windows, win_data_val_i per-lane valid
//   line/frame start/end _i            sideband flags aligned with win_data_i
//   coef_wr_i/coef_addr_i/coef_data_i  shadow kernel write port
//   coef_update_i, coef_pending_o      request shadow->active copy at next frame start
//   px_data_o, px_data_val_o           filtered pixels and per-lane valid
//   line/frame start/end _o            flags delayed to match px_data_o
module win_conv #(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4,
  parameter int WIN_SIZE   = 3,
  parameter int COEF_WIDTH = 8,
  parameter int NORM_SHIFT = 4
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_n_i,
  input  logic [PX_PER_CLK-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][PX_WIDTH-1:0] win_data_i,
  input  logic [PX_PER_CLK-1:0]                                  win_data_val_i,
  input  logic                                                   line_start_i,
  input  logic                                                   line_end_i,
  input  logic                                                   frame_start_i,
  input  logic                                                   frame_end_i,
  input  logic                                                   coef_wr_i,
  input  logic [$clog2(WIN_SIZE*WIN_SIZE)-1:0]                   coef_addr_i,
  input  logic [COEF_WIDTH-1:0]                                  coef_data_i,
  input  logic                                                   coef_update_i,
  output logic                                                   coef_pending_o,
  output logic [PX_PER_CLK-1:0][PX_WIDTH-1:0]                    px_data_o,
  output logic [PX_PER_CLK-1:0]                                  px_data_val_o,
  output logic                                                   line_start_o,
  output logic                                                   line_end_o,
  output logic                                                   frame_start_o,
  output logic                                                   frame_end_o
);

  localparam int NTAP   = WIN_SIZE * WIN_SIZE;
  localparam int AW     = $clog2(NTAP);
  localparam int CENTRE = (WIN_SIZE / 2) * WIN_SIZE + (WIN_SIZE / 2);

  // Widths grow stage by stage so no intermediate result can overflow;
  // the only saturation point is the final clamp.
  localparam int PROD_W = PX_WIDTH + 1 + COEF_WIDTH;
  localparam int ROW_W  = PROD_W + $clog2(WIN_SIZE);
  localparam int SUM_W  = PROD_W + $clog2(NTAP);

  // Half an LSB of the normalised result; evaluates to 0 when NORM_SHIFT is 0.
  localparam int RND_I = (1 << NORM_SHIFT) >> 1;

  localparam logic signed [SUM_W-1:0]      RND     = SUM_W'(RND_I);
  localparam logic signed [SUM_W-1:0]      PX_MAX  = SUM_W'((1 << PX_WIDTH) - 1);
  localparam logic signed [COEF_WIDTH-1:0] ID_COEF = COEF_WIDTH'(1 << NORM_SHIFT);

  // ---------------------------------------------------------------------------
  // Kernel storage (double buffered)
  // ---------------------------------------------------------------------------
  logic signed [COEF_WIDTH-1:0] shadow_q [NTAP];
  logic signed [COEF_WIDTH-1:0] active_q [NTAP];
  logic signed [COEF_WIDTH-1:0] kern_use [NTAP];
  logic                         pending_q;
  logic                         apply;

  // The copy happens on the first valid beat of a frame, and that same beat
  // must already see the new kernel, so S1 bypasses the active bank here.
  assign apply = frame_start_i & (|win_data_val_i) & (pending_q | coef_update_i);

  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      kern_use[i] = apply ? shadow_q[i] : active_q[i];
    end
  end

  // Active takes shadow as it was before this edge, so a write landing in the
  // same cycle as an apply only affects the next update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NTAP; i++) begin
        shadow_q[i] <= (i == CENTRE) ? ID_COEF : '0;
        active_q[i] <= (i == CENTRE) ? ID_COEF : '0;
      end
      pending_q <= 1'b0;
    end else begin
      if (coef_wr_i && (coef_addr_i < AW'(NTAP))) begin
        shadow_q[coef_addr_i] <= coef_data_i;
      end
      if (apply) begin
        active_q <= shadow_q;
      end
      pending_q <= apply ? 1'b0 : (pending_q | coef_update_i);
    end
  end

  assign coef_pending_o = pending_q;

  // ---------------------------------------------------------------------------
  // Valid and sideband delay line, one entry per pipeline stage
  // ---------------------------------------------------------------------------
  logic [3:0]            flags_in;
  logic [3:0]            flags_q [4];
  logic [PX_PER_CLK-1:0] val_q   [4];

  assign flags_in = {frame_end_i, frame_start_i, line_end_i, line_start_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < 4; s++) begin
        flags_q[s] <= '0;
        val_q[s]   <= '0;
      end
    end else begin
      flags_q[0] <= flags_in;
      val_q[0]   <= win_data_val_i;
      for (int s = 1; s < 4; s++) begin
        flags_q[s] <= flags_q[s-1];
        val_q[s]   <= val_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: per-tap products
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_d [PX_PER_CLK][NTAP];
  logic signed [PROD_W-1:0] prod_q [PX_PER_CLK][NTAP];

  always_comb begin
    for (int l = 0; l < PX_PER_CLK; l++) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE; c++) begin
          // Pixels are unsigned: a zero MSB makes them non-negative signed operands.
          prod_d[l][r*WIN_SIZE+c] = PROD_W'($signed({1'b0, win_data_i[l][r][c]}))
                                  * PROD_W'(kern_use[r*WIN_SIZE+c]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int l = 0; l < PX_PER_CLK; l++) begin
        for (int t = 0; t < NTAP; t++) begin
          prod_q[l][t] <= '0;
        end
      end
    end else begin
      prod_q <= prod_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: per-row partial sums
  // ---------------------------------------------------------------------------
  logic signed [ROW_W-1:0] row_d [PX_PER_CLK][WIN_SIZE];
  logic signed [ROW_W-1:0] row_q [PX_PER_CLK][WIN_SIZE];

  always_comb begin
    for (int l = 0; l < PX_PER_CLK; l++) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        row_d[l][r] = '0;
        for (int c = 0; c < WIN_SIZE; c++) begin
          row_d[l][r] = row_d[l][r] + ROW_W'(prod_q[l][r*WIN_SIZE+c]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int l = 0; l < PX_PER_CLK; l++) begin
        for (int r = 0; r < WIN_SIZE; r++) begin
          row_q[l][r] <= '0;
        end
      end
    end else begin
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: full window sum plus rounding offset
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] sum_d [PX_PER_CLK];
  logic signed [SUM_W-1:0] sum_q [PX_PER_CLK];

  always_comb begin
    for (int l = 0; l < PX_PER_CLK; l++) begin
      sum_d[l] = RND;
      for (int r = 0; r < WIN_SIZE; r++) begin
        sum_d[l] = sum_d[l] + SUM_W'(row_q[l][r]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int l = 0; l < PX_PER_CLK; l++) begin
        sum_q[l] <= '0;
      end
    end else begin
      sum_q <= sum_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S4: normalise (floor shift), clamp to the pixel range, mask invalid lanes
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0]            shifted [PX_PER_CLK];
  logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] px_d;
  logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] px_q;

  always_comb begin
    px_d = '0;
    for (int l = 0; l < PX_PER_CLK; l++) begin
      shifted[l] = sum_q[l] >>> NORM_SHIFT;
      if (!val_q[2][l] || shifted[l][SUM_W-1]) begin
        px_d[l] = '0;
      end else if (shifted[l] > PX_MAX) begin
        px_d[l] = '1;
      end else begin
        px_d[l] = shifted[l][PX_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px_q <= '0;
    end else begin
      px_q <= px_d;
    end
  end

  assign px_data_o     = px_q;
  assign px_data_val_o = val_q[3];
  assign line_start_o  = flags_q[3][0];
  assign line_end_o    = flags_q[3][1];
  assign frame_start_o = flags_q[3][2];
  assign frame_end_o   = flags_q[3][3];

endmodule

// File: tb/tb_win_conv.sv
// Directed bench for win_conv: identity, box, saturation, frame-boundary kernel
// update, lane masking and mid-stream reset, each checked against hand-computed values.
module tb_win_conv;

  localparam int PW = 12;
  localparam int L  = 4;
  localparam int W  = 3;
  localparam int CW = 8;
  localparam int NS = 4;

  logic                             clk_i = 1'b0;
  logic                             rst_n_i;
  logic [L-1:0][W-1:0][W-1:0][PW-1:0] win_data;
  logic [L-1:0]                     win_val;
  logic                             ls_i, le_i, fs_i, fe_i;
  logic                             coef_wr;
  logic [3:0]                       coef_addr;
  logic [CW-1:0]                    coef_data;
  logic                             coef_update;
  logic                             coef_pending;
  logic [L-1:0][PW-1:0]             px_data;
  logic [L-1:0]                     px_val;
  logic                             ls_o, le_o, fs_o, fe_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  win_conv #(
    .PX_WIDTH(PW), .PX_PER_CLK(L), .WIN_SIZE(W), .COEF_WIDTH(CW), .NORM_SHIFT(NS)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .win_data_i(win_data), .win_data_val_i(win_val),
    .line_start_i(ls_i), .line_end_i(le_i), .frame_start_i(fs_i), .frame_end_i(fe_i),
    .coef_wr_i(coef_wr), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .coef_update_i(coef_update), .coef_pending_o(coef_pending),
    .px_data_o(px_data), .px_data_val_o(px_val),
    .line_start_o(ls_o), .line_end_o(le_o), .frame_start_o(fs_o), .frame_end_o(fe_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every lane gets the same window: centre pixel ctr, all neighbours nb.
  task automatic beat(input logic [PW-1:0] ctr, input logic [PW-1:0] nb, input logic [L-1:0] val,
                      input logic fs, input logic fe, input logic ls, input logic le);
    for (int l = 0; l < L; l++)
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          win_data[l][r][c] = (r == 1 && c == 1) ? ctr : nb;
    win_val = val;
    fs_i = fs; fe_i = fe; ls_i = ls; le_i = le;
  endtask

  task automatic idle();
    beat('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [CW-1:0] d);
    coef_wr = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_wr = 1'b0;
  endtask

  task automatic upd();
    coef_update = 1'b1;
    tick();
    coef_update = 1'b0;
  endtask

  function automatic logic [3:0] flags_out();
    return {fe_o, fs_o, le_o, ls_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_update = 1'b0;
    idle();
    repeat (3) tick();

    // Reset state
    chk("rst_px",      px_data, 64'h0);
    chk("rst_val",     px_val, 64'h0);
    chk("rst_flags",   flags_out(), 64'h0);
    chk("rst_pending", coef_pending, 64'h0);

    rst_n_i = 1'b1;
    tick();

    // Identity kernel: output equals centre pixel, exactly 4 clocks later
    beat(12'h123, 12'hFFF, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick(); tick();
    chk("lat3_val",   px_val, 64'h0);
    chk("lat3_flags", flags_out(), 64'h0);
    tick();
    chk("id_px",    px_data, {4{12'h123}});
    chk("id_val",   px_val, 64'hF);
    chk("id_flags", flags_out(), 64'h5);
    tick();
    chk("id_flags_next", flags_out(), 64'h0);

    // Load box kernel into shadow; an out-of-range write must be ignored
    wr(4'd9, 8'h7F);
    wr(4'd15, 8'h55);
    for (int i = 0; i < 9; i++) wr(4'(i), 8'h01);
    chk("wr_no_pending", coef_pending, 64'h0);
    upd();
    chk("upd_pending", coef_pending, 64'h1);

    // Mid-frame beat keeps the identity kernel
    beat(12'h123, 12'hFFF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("midframe_pending", coef_pending, 64'h1);
    repeat (3) tick();
    chk("midframe_px", px_data, {4{12'h123}});

    // Frame start applies box: 9*100=900, (900+8)>>4 = 56
    beat(12'd100, 12'd100, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("apply_pending_clr", coef_pending, 64'h0);
    repeat (3) tick();
    chk("box_px", px_data, {4{12'h038}});

    // Lane masking with box still active
    beat(12'd100, 12'd100, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("mask_val", px_val, 64'h5);
    chk("mask_px",  px_data, {12'h000, 12'h038, 12'h000, 12'h038});

    // Saturation high: centre 127; a write to the centre on the apply beat
    // goes to shadow only and must not affect this frame
    for (int i = 0; i < 9; i++) wr(4'(i), (i == 4) ? 8'd127 : 8'd0);
    upd();
    beat(12'hFFF, 12'hFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    coef_wr = 1'b1; coef_addr = 4'd4; coef_data = 8'd0;
    tick();
    coef_wr = 1'b0;
    idle();
    chk("sathi_pending", coef_pending, 64'h0);
    repeat (3) tick();
    chk("sathi_px", px_data, {4{12'hFFF}});

    // Saturation low: neighbours -1, centre 0 from the earlier same-cycle write
    for (int i = 0; i < 9; i++) if (i != 4) wr(4'(i), 8'hFF);
    upd();
    beat(12'd100, 12'd100, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("satlo_px",  px_data, 64'h0);
    chk("satlo_val", px_val, 64'hF);

    // Reset mid-stream
    upd();
    chk("prerst_pending", coef_pending, 64'h1);
    beat(12'd100, 12'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    tick(); tick();
    chk("prerst_val",   px_val, 64'hF);
    chk("prerst_flags", flags_out(), 64'h2);
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_px",      px_data, 64'h0);
    chk("rst_mid_val",     px_val, 64'h0);
    chk("rst_mid_flags",   flags_out(), 64'h0);
    chk("rst_mid_pending", coef_pending, 64'h0);
    tick(); tick();
    rst_n_i = 1'b1;
    repeat (5) tick();
    chk("postrst_val", px_val, 64'h0);

    // Kernel back to identity after reset
    beat(12'h123, 12'hFFF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (3) tick();
    chk("postrst_id_px", px_data, {4{12'h123}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
